// File: rtl/qr_pkg.sv
// -----------------------------------------------------------------------------
// qr_pkg
// Shared constants and types for the QR finder-pattern scanner.
//   FRAME_WIDTH / FRAME_HEIGHT : camera frame geometry (pixels per row, rows)
//   HIST_RUN_W                 : width of one stored run length
//   UNIT_TOL_SHIFT             : T >> n tolerance for the four unit runs
//   CTR_TOL_SHIFT              : T >> n tolerance for the 3-unit centre run
//   run_hist_t                 : five newest closed runs, start of r3, row
// Build option: define FINDER_SCAN_STRICT_TOL_EN for the tighter tolerances.
// -----------------------------------------------------------------------------
package qr_pkg;

  localparam int FRAME_WIDTH  = 320;
  localparam int FRAME_HEIGHT = 240;
  localparam int HIST_RUN_W   = 8;

`ifdef FINDER_SCAN_STRICT_TOL_EN
  localparam int UNIT_TOL_SHIFT = 2;
  localparam int CTR_TOL_SHIFT  = 1;
`else
  localparam int UNIT_TOL_SHIFT = 1;
  localparam int CTR_TOL_SHIFT  = 0;
`endif

  // r1 is the oldest closed run, r5 the newest.
  typedef struct packed {
    logic [HIST_RUN_W-1:0] r1;
    logic [HIST_RUN_W-1:0] r2;
    logic [HIST_RUN_W-1:0] r3;
    logic [HIST_RUN_W-1:0] r4;
    logic [HIST_RUN_W-1:0] r5;
    logic [8:0]            start3;
    logic [7:0]            row;
  } run_hist_t;

  function automatic logic [11:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // 7*r without a multiplier: (r << 3) - r, fits 12 bits for 8-bit runs.
  function automatic logic [11:0] times7(input logic [HIST_RUN_W-1:0] r);
    logic [11:0] r12;
    r12 = 12'(r);
    return (r12 << 3) - r12;
  endfunction

endpackage

// File: rtl/finder_ratio_check.sv
// -----------------------------------------------------------------------------
// finder_ratio_check
// Registered 1:1:3:1:1 ratio test on five closed runs. One result per cycle.
// Ports:
//   clk_in, rst_in   : pixel clock, synchronous active-high reset
//   eval_in          : hist_in holds a D-L-D-L-D candidate this cycle
//   hist_in          : run history snapshot (run_hist_t)
//   pass_out         : candidate matched (one cycle after eval_in)
//   centre_out       : column of the centre run's midpoint
//   row_out          : row of the newest run
// Tolerances come from qr_pkg (FINDER_SCAN_STRICT_TOL_EN selects them).
// -----------------------------------------------------------------------------
module finder_ratio_check
  import qr_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       eval_in,
  input  run_hist_t  hist_in,
  output logic       pass_out,
  output logic [8:0] centre_out,
  output logic [7:0] row_out
);

  logic [10:0] total;
  logic [11:0] t12;
  logic [11:0] three_t;
  logic [11:0] unit_tol;
  logic [11:0] ctr_tol;
  logic        unit_ok;
  logic        ctr_ok;
  logic        pass_c;

  always_comb begin
    total    = 11'(hist_in.r1) + 11'(hist_in.r2) + 11'(hist_in.r3)
             + 11'(hist_in.r4) + 11'(hist_in.r5);
    t12      = 12'(total);
    three_t  = (t12 << 1) + t12;
    unit_tol = t12 >> UNIT_TOL_SHIFT;
    ctr_tol  = t12 >> CTR_TOL_SHIFT;
    // Scaling every run by 7 (the module count) avoids dividing T by 7.
    unit_ok  = (abs_diff(times7(hist_in.r1), t12) <= unit_tol)
            && (abs_diff(times7(hist_in.r2), t12) <= unit_tol)
            && (abs_diff(times7(hist_in.r4), t12) <= unit_tol)
            && (abs_diff(times7(hist_in.r5), t12) <= unit_tol);
    ctr_ok   = abs_diff(times7(hist_in.r3), three_t) <= ctr_tol;
    pass_c   = eval_in && (total >= 11'd7) && unit_ok && ctr_ok;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pass_out   <= 1'b0;
      centre_out <= '0;
      row_out    <= '0;
    end else begin
      pass_out <= pass_c;
      if (eval_in) begin
        centre_out <= hist_in.start3 + 9'(hist_in.r3 >> 1);
        row_out    <= hist_in.row;
      end
    end
  end

endmodule

// File: rtl/finder_scan.sv
// -----------------------------------------------------------------------------
// finder_scan
// Streams binarized pixels, run-length encodes each row and flags QR finder
// patterns (dark-light-dark-light-dark at 1:1:3:1:1). Counts hits per frame.
// Ports:
//   clk_in, rst_in        : pixel clock, synchronous active-high reset
//   pixel_in, valid_in    : pixel (0 dark, 1 light) and its qualifier
//   hcount_in, vcount_in  : pixel column / row
//   frame_done_in         : end-of-frame pulse
//   hit_valid_out         : one-cycle hit strobe, 2 cycles after the closing pixel
//   hit_hcount_out        : centre column of the hit (held between hits)
//   hit_vcount_out        : row of the hit (held between hits)
//   frame_hits_out        : hit total of the last completed frame (sat. 255)
// Build option: FINDER_SCAN_STRICT_TOL_EN tightens the ratio tolerances.
// -----------------------------------------------------------------------------
module finder_scan
  import qr_pkg::*;
#(
  parameter int WIDTH  = FRAME_WIDTH,
  parameter int HEIGHT = FRAME_HEIGHT,
  parameter int RUN_W  = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       pixel_in,
  input  logic       valid_in,
  input  logic [8:0] hcount_in,
  input  logic [7:0] vcount_in,
  input  logic       frame_done_in,
  output logic       hit_valid_out,
  output logic [8:0] hit_hcount_out,
  output logic [7:0] hit_vcount_out,
  output logic [7:0] frame_hits_out
);

  localparam logic [8:0]       LAST_COL = 9'(WIDTH - 1);
  localparam logic [8:0]       COLS     = 9'(WIDTH);
  localparam logic [7:0]       ROWS     = 8'(HEIGHT);
  localparam logic [RUN_W-1:0] RUN_MAX  = {RUN_W{1'b1}};

  // current (open) run
  logic             run_active;
  logic             run_colour;
  logic [RUN_W-1:0] run_len;
  logic [8:0]       run_start;
  // closed runs this row, saturating at 5
  logic [2:0]       closed_cnt;
  run_hist_t        hist;
  logic [8:0]       start4;
  logic [8:0]       start5;
  logic             eval_q;

  logic             accept;
  logic             row_start;
  logic             row_end;
  logic             colour_chg;
  logic             same_run;
  logic             close_run;
  logic [RUN_W-1:0] len_inc;
  logic [RUN_W-1:0] close_len;
  logic [2:0]       cnt_nxt;
  logic             eval_fire;

  logic             chk_pass;
  logic [8:0]       chk_centre;
  logic [7:0]       chk_row;
  logic [7:0]       frame_cnt;

  always_comb begin
    accept     = valid_in && (hcount_in < COLS) && (vcount_in < ROWS);
    row_start  = accept && (hcount_in == 9'd0);
    row_end    = accept && (hcount_in == LAST_COL);
    colour_chg = accept && run_active && !row_start && (pixel_in != run_colour);
    same_run   = accept && run_active && !row_start && (pixel_in == run_colour);
    len_inc    = (run_len == RUN_MAX) ? run_len : run_len + RUN_W'(1);
    // At the row end a colour change closes the older run; the one-pixel run
    // started by the last column is dropped with the rest of the history.
    close_run  = colour_chg || (row_end && same_run);
    close_len  = colour_chg ? run_len : len_inc;
    cnt_nxt    = (closed_cnt == 3'd5) ? closed_cnt : closed_cnt + 3'd1;
    // Runs alternate, so a dark r5 with five closures means D-L-D-L-D.
    eval_fire  = close_run && !run_colour && (cnt_nxt == 3'd5);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      run_active <= 1'b0;
      run_colour <= 1'b0;
      run_len    <= '0;
      run_start  <= '0;
      closed_cnt <= '0;
      hist       <= '0;
      start4     <= '0;
      start5     <= '0;
      eval_q     <= 1'b0;
    end else if (frame_done_in) begin
      run_active <= 1'b0;
      closed_cnt <= '0;
      eval_q     <= 1'b0;
    end else begin
      eval_q <= eval_fire;
      if (close_run) begin
        hist.r1     <= hist.r2;
        hist.r2     <= hist.r3;
        hist.r3     <= hist.r4;
        hist.r4     <= hist.r5;
        hist.r5     <= HIST_RUN_W'(close_len);
        hist.start3 <= start4;
        start4      <= start5;
        start5      <= run_start;
        hist.row    <= vcount_in;
      end
      // Row end only drops the count; the stored runs stay for the evaluation
      // of this final closure one cycle later.
      if (row_end) begin
        run_active <= 1'b0;
        closed_cnt <= '0;
      end else if (accept) begin
        if (row_start) begin
          closed_cnt <= '0;
        end else if (close_run) begin
          closed_cnt <= cnt_nxt;
        end
        if (same_run) begin
          run_len <= len_inc;
        end else begin
          run_active <= 1'b1;
          run_colour <= pixel_in;
          run_len    <= RUN_W'(1);
          run_start  <= hcount_in;
        end
      end
    end
  end

  finder_ratio_check u_ratio (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .eval_in    (eval_q),
    .hist_in    (hist),
    .pass_out   (chk_pass),
    .centre_out (chk_centre),
    .row_out    (chk_row)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hit_valid_out  <= 1'b0;
      hit_hcount_out <= '0;
      hit_vcount_out <= '0;
    end else begin
      hit_valid_out <= chk_pass;
      if (chk_pass) begin
        hit_hcount_out <= chk_centre;
        hit_vcount_out <= chk_row;
      end
    end
  end

  // A hit on the frame_done cycle belongs to the frame being closed.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      frame_cnt      <= '0;
      frame_hits_out <= '0;
    end else if (frame_done_in) begin
      frame_hits_out <= (hit_valid_out && frame_cnt != 8'hFF) ? frame_cnt + 8'd1 : frame_cnt;
      frame_cnt      <= '0;
    end else if (hit_valid_out && frame_cnt != 8'hFF) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_finder_scan.sv
// Directed bench for finder_scan: hand-built rows with known run patterns.
module tb_finder_scan;

`ifdef FINDER_SCAN_STRICT_TOL_EN
  localparam int STRICT = 1;
`else
  localparam int STRICT = 0;
`endif

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       pixel_in = 1'b1;
  logic       valid_in = 1'b0;
  logic [8:0] hcount_in = '0;
  logic [7:0] vcount_in = '0;
  logic       frame_done_in = 1'b0;
  logic       hit_valid_out;
  logic [8:0] hit_hcount_out;
  logic [7:0] hit_vcount_out;
  logic [7:0] frame_hits_out;

  finder_scan dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .pixel_in       (pixel_in),
    .valid_in       (valid_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .frame_done_in  (frame_done_in),
    .hit_valid_out  (hit_valid_out),
    .hit_hcount_out (hit_hcount_out),
    .hit_vcount_out (hit_vcount_out),
    .frame_hits_out (frame_hits_out)
  );

  always #5 clk_in = ~clk_in;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   n_hits = 0;
  int   last_hit_cyc = -1;
  int   exp_cyc = -2;
  int   h0;
  logic pix_row [0:319];

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (hit_valid_out === 1'b1) begin
      n_hits = n_hits + 1;
      last_hit_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_light();
    for (int i = 0; i < 320; i++) pix_row[i] = 1'b1;
  endtask

  task automatic set_dark(input int a, input int b);
    for (int i = a; i <= b; i++) pix_row[i] = 1'b0;
  endtask

  // mark_col: pixel whose acceptance should produce the hit (-1 none);
  // fd_col / rst_col: column at which frame_done_in / rst_in pulse (-1 none).
  task automatic send_row(input int row, input int mark_col, input int fd_col, input int rst_col);
    for (int h = 0; h < 320; h++) begin
      @(negedge clk_in);
      valid_in      = 1'b1;
      pixel_in      = pix_row[h];
      hcount_in     = 9'(h);
      vcount_in     = 8'(row);
      frame_done_in = (h == fd_col);
      rst_in        = (h == rst_col);
      if (h == mark_col) exp_cyc = cyc + 3;
    end
    @(negedge clk_in);
    valid_in      = 1'b0;
    frame_done_in = 1'b0;
    rst_in        = 1'b0;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic pulse_fd();
    @(negedge clk_in);
    frame_done_in = 1'b1;
    @(negedge clk_in);
    frame_done_in = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic pattern_base();
    set_light();
    set_dark(20, 29);
    set_dark(40, 69);
    set_dark(80, 89);
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("rst_valid", hit_valid_out, 0);
    chk("rst_hcount", hit_hcount_out, 0);
    chk("rst_vcount", hit_vcount_out, 0);
    chk("rst_frame_hits", frame_hits_out, 0);

    // 10,10,30,10,10 : hit at 40+15
    pattern_base();
    h0 = n_hits;
    send_row(100, 90, -1, -1);
    chk("r100_hits", n_hits - h0, 1);
    chk("r100_latency", last_hit_cyc, exp_cyc);
    chk("r100_hcount", hit_hcount_out, 55);
    chk("r100_vcount", hit_vcount_out, 100);

    // 10,10,10,10,10 : centre fails, outputs held
    set_light();
    set_dark(20, 29);
    set_dark(40, 49);
    set_dark(60, 69);
    h0 = n_hits;
    send_row(100, -1, -1, -1);
    chk("r100_even_hits", n_hits - h0, 0);
    chk("r100_even_hold", hit_hcount_out, 55);

    // 10,14,30,10,10 : unit run 14 within T>>1 but outside T>>2
    set_light();
    set_dark(20, 29);
    set_dark(44, 73);
    set_dark(84, 93);
    h0 = n_hits;
    send_row(101, 94, -1, -1);
    chk("r101_hits", n_hits - h0, STRICT ? 0 : 1);
    chk("r101_hcount", hit_hcount_out, STRICT ? 55 : 59);
    chk("r101_vcount", hit_vcount_out, STRICT ? 100 : 101);

    // pattern ending on the last column
    set_light();
    set_dark(250, 259);
    set_dark(270, 299);
    set_dark(310, 319);
    h0 = n_hits;
    send_row(102, 319, -1, -1);
    chk("r102_hits", n_hits - h0, 1);
    chk("r102_latency", last_hit_cyc, exp_cyc);
    chk("r102_hcount", hit_hcount_out, 285);
    chk("r102_vcount", hit_vcount_out, 102);

    // next row starts fresh: pattern from column 0
    set_light();
    set_dark(0, 9);
    set_dark(20, 49);
    set_dark(60, 69);
    h0 = n_hits;
    send_row(103, 70, -1, -1);
    chk("r103_hits", n_hits - h0, 1);
    chk("r103_latency", last_hit_cyc, exp_cyc);
    chk("r103_hcount", hit_hcount_out, 35);

    pulse_fd();
    chk("frame1_hits", frame_hits_out, STRICT ? 3 : 4);

    // two hits, then frame_done on the cycle of the third hit
    pattern_base();
    h0 = n_hits;
    send_row(110, 90, -1, -1);
    send_row(111, 90, -1, -1);
    send_row(112, 90, 93, -1);
    chk("frame2_seen", n_hits - h0, 3);
    chk("frame2_hits", frame_hits_out, 3);

    send_row(113, 90, -1, -1);
    pulse_fd();
    chk("frame3_hits", frame_hits_out, 1);

    // reset pulse at column 85 of the hit row
    h0 = n_hits;
    send_row(114, -1, -1, 85);
    chk("rst_row_hits", n_hits - h0, 0);
    chk("rst_row_valid", hit_valid_out, 0);
    chk("rst_row_hcount", hit_hcount_out, 0);
    chk("rst_row_vcount", hit_vcount_out, 0);
    chk("rst_row_frame_hits", frame_hits_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
